div_ctrl: RTL

//  Multi-cycle controller for MIPS DIV/DIVU in the EX stage. Sequences a

---
 rtl/div_pkg.sv | 15 +
 rtl/div_ctrl_if.sv | 25 ++
 rtl/div_step.sv | 24 ++
 rtl/div_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the DIV/DIVU controller: widths and FSM state codes.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef logic [2:0] div_state_t;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] CALC = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake and result bundle between the EX stage (master) and div_ctrl (slave).
interface div_ctrl_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, signed_div, opa, opb, cancel,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, signed_div, opa, opb, cancel,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {r,q} left, subtract divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] r_sh;

    // One extra bit so the shifted remainder never wraps before the compare.
    always_comb begin
        r_sh = {r_i, q_i[WIDTH-1]};
        if (r_sh >= {1'b0, d_i}) begin
            r_o = WIDTH'(r_sh - {1'b0, d_i});
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            r_o = r_sh[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle MIPS DIV/DIVU controller: sign prep, WIDTH restoring steps, sign fix.
// Optional macro DIV_ZERO_TRAP_EN: zero divisor short-circuits to DONE with div_zero=1.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic       clk,
    input logic       resetn,
    div_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
    logic             zero_q, zero_d;
    logic             dz_q, dz_d;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] step_r, step_q;

    // dvd_q carries the dividend in, quotient bits shift in from the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (rem_q),
        .q_i (dvd_q),
        .d_i (dvs_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    assign a_neg = sgn_q & dvd_q[WIDTH-1];
    assign b_neg = sgn_q & dvs_q[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        done_d    = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        zero_d    = zero_q;
        dz_d      = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    dvd_d   = bus.opa;
                    dvs_d   = bus.opb;
                    sgn_d   = bus.signed_div;
                    state_d = PREP;
                end
            end
            PREP: begin
                dvd_d   = a_neg ? -dvd_q : dvd_q;
                dvs_d   = b_neg ? -dvs_q : dvs_q;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                rem_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = CALC;
`ifdef DIV_ZERO_TRAP_EN
                zero_d  = 1'b0;
                if (dvs_q == '0) begin
                    dvd_d   = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                rem_d = step_r;
                dvd_d = step_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                dvd_d   = qneg_q ? -dvd_q : dvd_q;
                rem_d   = rneg_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                quo_out_d = dvd_q;
                rem_out_d = rem_q;
                done_d    = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                dz_d      = zero_q;
`endif
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush drops the operation and leaves the visible results untouched.
        if (bus.cancel && (state_q != IDLE)) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            quo_out_d = quo_out_q;
            rem_out_d = rem_out_q;
`ifdef DIV_ZERO_TRAP_EN
            dz_d      = dz_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            done_q    <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            zero_q    <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            done_q    <= done_d;
`ifdef DIV_ZERO_TRAP_EN
            zero_q    <= zero_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = quo_out_q;
    assign bus.remainder = rem_out_q;
`ifdef DIV_ZERO_TRAP_EN
    assign bus.div_zero  = dz_q;
`else
    assign bus.div_zero  = 1'b0;
`endif
endmodule
